// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the IF stage and instruction memory.
// The fetch stage is the master; memory is the slave.
interface if_fetch_stage_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  req;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  ack;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// IF-stage fetch control: req/ack handshake with instruction memory, PC write enable and
// the IF/ID pipeline register, with a one-entry skid buffer for data acked under stall.
module if_fetch_stage #(
   parameter int unsigned          ADDR_WIDTH = 32,
   parameter int unsigned          DATA_WIDTH = 32,
   parameter int unsigned          PC_INCR    = 4,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   output logic                  pc_write,
   if_fetch_stage_if.master      imem,
   input  logic                  stall,
   input  logic                  flush,
   output logic                  if_id_valid,
   output logic [DATA_WIDTH-1:0] if_id_instr,
   output logic [ADDR_WIDTH-1:0] if_id_pc_plus4
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold, StDrain} state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  skid_valid_q, skid_valid_d;
   logic [DATA_WIDTH-1:0] skid_instr_q, skid_instr_d;
   logic [ADDR_WIDTH-1:0] skid_pc4_q, skid_pc4_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic [ADDR_WIDTH-1:0] pc4_q, pc4_d;
   logic [ADDR_WIDTH-1:0] pc_plus;

   assign pc_plus = pc_in + ADDR_WIDTH'(PC_INCR);

   always_comb begin
      state_d      = state_q;
      pc_write     = 1'b0;
      imem.req     = 1'b0;
      imem.addr    = pc_in;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      pc4_d        = pc4_q;

      unique case (state_q)
         StIdle: begin
            state_d = StFetch;
            if (!stall) begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
            end
         end
         StFetch: begin
            imem.req = 1'b1;
            if (flush) begin
               // An unacked request must still complete; its data is dropped in StDrain.
               if (!imem.ack) state_d = StDrain;
            end else if (imem.ack && !stall) begin
               pc_write = 1'b1;
               valid_d  = 1'b1;
               instr_d  = imem.rdata;
               pc4_d    = pc_plus;
            end else if (imem.ack) begin
               skid_valid_d = 1'b1;
               skid_instr_d = imem.rdata;
               skid_pc4_d   = pc_plus;
               state_d      = StHold;
            end else if (!stall) begin
               valid_d = 1'b0;
               instr_d = NOP_INSTR;
            end
         end
         StHold: begin
            if (flush) begin
               state_d = StFetch;
            end else if (!stall) begin
               pc_write     = 1'b1;
               valid_d      = skid_valid_q;
               instr_d      = skid_instr_q;
               pc4_d        = skid_pc4_q;
               skid_valid_d = 1'b0;
               state_d      = StFetch;
            end
         end
         StDrain: begin
            imem.req  = 1'b1;
            imem.addr = addr_q;
            if (!flush) begin
               if (imem.ack) state_d = StFetch;
               if (!stall) begin
                  valid_d = 1'b0;
                  instr_d = NOP_INSTR;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Redirect wins over stall and ack: advance the PC to the target and insert a bubble.
      if (flush) begin
         pc_write     = 1'b1;
         valid_d      = 1'b0;
         instr_d      = NOP_INSTR;
         skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= NOP_INSTR;
         skid_pc4_q   <= '0;
         valid_q      <= 1'b0;
         instr_q      <= NOP_INSTR;
         pc4_q        <= '0;
      end else begin
         state_q      <= state_d;
         if (state_q == StFetch) addr_q <= pc_in;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         pc4_q        <= pc4_d;
      end
   end

   assign if_id_valid    = valid_q;
   assign if_id_instr    = instr_q;
   assign if_id_pc_plus4 = pc4_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations, then randomized
// memory latency / stall / flush traffic checked every cycle against a behavioural model.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc_in;
   logic        pc_write;
   logic        stall, flush;
   logic        if_id_valid;
   logic [31:0] if_id_instr, if_id_pc_plus4;

   if_fetch_stage_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) imem ();

   if_fetch_stage #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .PC_INCR(4), .NOP_INSTR(NOP)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .pc_in          (pc_in),
      .pc_write       (pc_write),
      .imem           (imem),
      .stall          (stall),
      .flush          (flush),
      .if_id_valid    (if_id_valid),
      .if_id_instr    (if_id_instr),
      .if_id_pc_plus4 (if_id_pc_plus4)
   );

   always #5 clock = ~clock;

   typedef struct {logic [31:0] instr; logic [31:0] pc4;} entry_t;

   // Behavioural model: the PC register, whether fetching has begun, a pending discard,
   // and a queue of instructions accepted by memory but not yet passed to ID.
   logic [31:0] pc;
   bit          m_started, m_draining;
   logic [31:0] m_drain_addr;
   entry_t      m_skid[$];
   logic        m_valid;
   logic [31:0] m_instr, m_pc4;

   int          checks = 0, failures = 0, pcw_count = 0, mem_cnt = 0;
   logic        s_req, s_pcw;
   logic [31:0] s_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_started  = 0;
      m_draining = 0;
      m_skid.delete();
      m_valid    = 1'b0;
      m_instr    = NOP;
      m_pc4      = 32'h0;
   endtask

   function automatic logic exp_req();
      return m_started && (m_skid.size() == 0);
   endfunction

   function automatic logic exp_pcw(input logic ack, input logic st, input logic fl);
      if (fl) return 1'b1;
      if (!m_started) return 1'b0;
      if (m_skid.size() != 0) return !st;
      if (m_draining) return 1'b0;
      return ack && !st;
   endfunction

   task automatic bubble();
      m_valid = 1'b0;
      m_instr = NOP;
   endtask

   // One clock cycle: drive, compare every output against the model, clock, advance model.
   task automatic cycle(input logic ack, input logic st, input logic fl,
                        input logic [31:0] rdata, input logic [31:0] target);
      logic   er, ep;
      entry_t e;
      imem.ack   = ack;
      imem.rdata = rdata;
      stall      = st;
      flush      = fl;
      pc_in      = pc;
      #3;
      er = exp_req();
      ep = exp_pcw(ack, st, fl);
      chk("req", {31'b0, imem.req}, {31'b0, er});
      if (er) chk("addr", imem.addr, m_draining ? m_drain_addr : pc);
      chk("pc_write", {31'b0, pc_write}, {31'b0, ep});
      chk("if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      chk("if_id_instr", if_id_instr, m_instr);
      chk("if_id_pc_plus4", if_id_pc_plus4, m_pc4);
      s_req  = imem.req;
      s_addr = imem.addr;
      s_pcw  = pc_write;
      if (pc_write) pcw_count++;
      @(posedge clock);
      if (!m_started) begin
         m_started = 1;
         if (fl || !st) bubble();
      end else if (m_skid.size() != 0) begin
         if (fl) begin
            m_skid.delete();
            bubble();
         end else if (!st) begin
            e       = m_skid.pop_front();
            m_valid = 1'b1;
            m_instr = e.instr;
            m_pc4   = e.pc4;
         end
      end else if (m_draining) begin
         if (fl) bubble();
         else begin
            if (ack) m_draining = 0;
            if (!st) bubble();
         end
      end else begin
         if (fl) begin
            bubble();
            if (!ack) begin
               m_draining   = 1;
               m_drain_addr = pc;
            end
         end else if (ack && !st) begin
            m_valid = 1'b1;
            m_instr = rdata;
            m_pc4   = pc + 32'd4;
         end else if (ack) begin
            e.instr = rdata;
            e.pc4   = pc + 32'd4;
            m_skid.push_back(e);
         end else if (!st) bubble();
      end
      if (ep) pc = fl ? target : pc + 32'd4;
      #1;
   endtask

   task automatic do_reset(input logic [31:0] pc0);
      reset      = 1'b0;
      imem.ack   = 1'b0;
      imem.rdata = 32'h0;
      stall      = 1'b0;
      flush      = 1'b0;
      pc         = pc0;
      pc_in      = pc0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      chk("rst_req", {31'b0, imem.req}, 32'd0);
      chk("rst_pc_write", {31'b0, pc_write}, 32'd0);
      chk("rst_valid", {31'b0, if_id_valid}, 32'd0);
      chk("rst_instr", if_id_instr, NOP);
      chk("rst_pc4", if_id_pc_plus4, 32'h0);
      reset = 1'b1;
   endtask

   initial begin
      logic        a, st, fl;
      logic [31:0] tgt;

      // Zero-wait memory from PC 0: one instruction per cycle.
      do_reset(32'h0);
      cycle(0, 0, 0, 32'h0, 32'h0);
      pcw_count = 0;
      for (int i = 0; i < 3; i++) begin
         cycle(1, 0, 0, 32'h1000 + i, 32'h0);
         chk("t1_pc4", if_id_pc_plus4, 32'd4 * (i + 1));
      end
      chk("t1_pcw_count", pcw_count, 3);

      // Three-cycle memory latency at 0x20.
      do_reset(32'h20);
      cycle(0, 0, 0, 32'h0, 32'h0);
      pcw_count = 0;
      repeat (3) begin
         cycle(0, 0, 0, 32'h0, 32'h0);
         chk("t2_addr", s_addr, 32'h20);
      end
      cycle(1, 0, 0, 32'h1111_1111, 32'h0);
      chk("t2_pcw_count", pcw_count, 1);
      chk("t2_pc4", if_id_pc_plus4, 32'h24);

      // Stall on the ack cycle, release two cycles later.
      pcw_count = 0;
      cycle(1, 1, 0, 32'h8C22_0004, 32'h0);
      cycle(0, 1, 0, 32'h0, 32'h0);
      chk("t3_pcw_held", pcw_count, 0);
      chk("t3_instr_held", if_id_instr, 32'h1111_1111);
      cycle(0, 0, 0, 32'h0, 32'h0);
      chk("t3_instr", if_id_instr, 32'h8C22_0004);
      chk("t3_pc4", if_id_pc_plus4, 32'h28);
      chk("t3_pcw_count", pcw_count, 1);

      // Flush before ack: the pending fetch is drained and its data dropped.
      do_reset(32'h10);
      cycle(0, 0, 0, 32'h0, 32'h0);
      cycle(0, 0, 1, 32'h0, 32'h40);
      chk("t4_pcw", {31'b0, s_pcw}, 32'd1);
      chk("t4_valid", {31'b0, if_id_valid}, 32'd0);
      cycle(0, 0, 0, 32'h0, 32'h0);
      chk("t4_drain_addr", s_addr, 32'h10);
      cycle(1, 0, 0, 32'hDEAD_BEEF, 32'h0);
      chk("t4_drain_addr_ack", s_addr, 32'h10);
      chk("t4_dropped", if_id_instr, NOP);
      cycle(1, 0, 0, 32'h2222_2222, 32'h0);
      chk("t4_new_addr", s_addr, 32'h40);
      chk("t4_instr", if_id_instr, 32'h2222_2222);

      // PC+4 wraps at the top of the address space.
      do_reset(32'hFFFF_FFFC);
      cycle(0, 0, 0, 32'h0, 32'h0);
      cycle(1, 0, 0, 32'h3333_3333, 32'h0);
      chk("t5_pc4_wrap", if_id_pc_plus4, 32'h0);
      chk("t5_valid", {31'b0, if_id_valid}, 32'd1);

      // Asynchronous reset in the middle of a fetch cycle.
      do_reset(32'h0);
      cycle(0, 0, 0, 32'h0, 32'h0);
      cycle(1, 0, 0, 32'h4444_4444, 32'h0);
      imem.ack = 1'b0;
      pc_in    = pc;
      #2 reset = 1'b0;
      #1;
      chk("t6_req", {31'b0, imem.req}, 32'd0);
      chk("t6_valid", {31'b0, if_id_valid}, 32'd0);
      chk("t6_instr", if_id_instr, NOP);
      do_reset(32'h0);
      cycle(0, 0, 0, 32'h0, 32'h0);
      chk("t6_idle_req", {31'b0, s_req}, 32'd0);
      cycle(0, 0, 0, 32'h0, 32'h0);
      chk("t6_req_after", {31'b0, s_req}, 32'd1);
      chk("t6_addr_after", s_addr, 32'h0);

      // Randomized traffic: memory acks a request after 0..3 cycles.
      do_reset(32'h0);
      mem_cnt = 0;
      for (int n = 0; n < 4000; n++) begin
         a = 1'b0;
         if (exp_req()) begin
            if (mem_cnt == 0) begin
               a       = 1'b1;
               mem_cnt = $urandom_range(0, 3);
            end else mem_cnt--;
         end
         st  = ($urandom_range(0, 2) == 0);
         fl  = ($urandom_range(0, 7) == 0);
         tgt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom(), 2'b00} >> 0;
         tgt[1:0] = 2'b00;
         cycle(a, st, fl, $urandom(), tgt);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
